// File: rtl/iso16_delivery_controller.sv
// iso16_delivery_controller: accumulates SAMPLE_COUNT warp/error samples, checks symmetry and error budget, then requests a seal (DONE) or aborts (FAIL); ports: start/busy control, s_* sample stream, sums and check flags, seal_* engine handshake, done/timeout status
module iso16_delivery_controller #(
  parameter int WARP_WIDTH = 16,
  parameter int ERROR_WIDTH = 32,
  parameter int SAMPLE_COUNT = 4,
  parameter int SYM_TOL = 0,
  parameter int ERR_LIMIT = 16,
  parameter int SEAL_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [WARP_WIDTH-1:0]  s_x,
  input  logic signed [WARP_WIDTH-1:0]  s_y,
  input  logic signed [WARP_WIDTH-1:0]  s_z,
  input  logic [ERROR_WIDTH-1:0]        s_err,
  output logic [2:0]                    state,
  output logic signed [WARP_WIDTH-1:0]  warp_sum_x,
  output logic signed [WARP_WIDTH-1:0]  warp_sum_y,
  output logic signed [WARP_WIDTH-1:0]  warp_sum_z,
  output logic [ERROR_WIDTH-1:0]        error_sum,
  output logic                          symmetry_ok,
  output logic                          error_ok,
  output logic                          true_delivery,
  output logic                          seal_start,
  input  logic                          seal_ready,
  input  logic [255:0]                  seal_in,
  output logic [255:0]                  seal,
  output logic                          done,
  output logic                          timeout
);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, EVAL, CHECK, SEAL, DONE, FAIL} st_t;
  localparam logic [WARP_WIDTH:0] TOL = (WARP_WIDTH+1)'(SYM_TOL);
  localparam logic [WARP_WIDTH:0] HALF = {2'b01, {(WARP_WIDTH-1){1'b0}}};
  localparam logic [ERROR_WIDTH-1:0] ELIM = ERROR_WIDTH'(ERR_LIMIT);
  localparam logic [7:0] LAST = 8'(SAMPLE_COUNT-1);
  localparam logic [15:0] TMAX = 16'(SEAL_TIMEOUT-1);
  st_t st;
  logic [7:0] cnt;
  logic [15:0] wcnt;
  logic ovf, sym_c, err_c;
  logic signed [WARP_WIDTH-1:0] nx, ny, nz;
  logic [ERROR_WIDTH:0] ne;
  function automatic logic in_tol(logic [WARP_WIDTH-1:0] v);
    logic [WARP_WIDTH:0] m;
    m = v[WARP_WIDTH-1] ? -{1'b1, v} : {1'b0, v};
    return m < HALF && m <= TOL;
  endfunction
  function automatic logic ovf_add(logic a, logic b, logic s);
    return a == b && s != a;
  endfunction
  always_comb begin
    nx = warp_sum_x + s_x;
    ny = warp_sum_y + s_y;
    nz = warp_sum_z + s_z;
    ne = {1'b0, error_sum} + {1'b0, s_err};
    sym_c = !ovf && in_tol(warp_sum_x) && in_tol(warp_sum_y) && in_tol(warp_sum_z);
    err_c = error_sum <= ELIM;
  end
  assign state = st;
  assign busy = st != IDLE;
  assign s_ready = st == ACCUM;
  assign seal_start = st == SEAL && wcnt == 16'd0;
  assign done = st == DONE || st == FAIL;
  always_ff @(posedge clk) begin
    if (rst || st == CLEAR) begin
      warp_sum_x <= '0;
      warp_sum_y <= '0;
      warp_sum_z <= '0;
      error_sum <= '0;
      cnt <= '0;
      wcnt <= '0;
      ovf <= 1'b0;
      symmetry_ok <= 1'b0;
      error_ok <= 1'b0;
      true_delivery <= 1'b0;
      seal <= '0;
      timeout <= 1'b0;
    end
    if (rst) st <= IDLE;
    else case (st)
      IDLE: st <= start ? CLEAR : IDLE;
      CLEAR: st <= ACCUM;
      ACCUM: if (s_valid) begin
        warp_sum_x <= nx;
        warp_sum_y <= ny;
        warp_sum_z <= nz;
        error_sum <= ne[ERROR_WIDTH] ? '1 : ne[ERROR_WIDTH-1:0];
        ovf <= ovf | ovf_add(warp_sum_x[WARP_WIDTH-1], s_x[WARP_WIDTH-1], nx[WARP_WIDTH-1])
                   | ovf_add(warp_sum_y[WARP_WIDTH-1], s_y[WARP_WIDTH-1], ny[WARP_WIDTH-1])
                   | ovf_add(warp_sum_z[WARP_WIDTH-1], s_z[WARP_WIDTH-1], nz[WARP_WIDTH-1]);
        cnt <= cnt + 8'd1;
        st <= cnt == LAST ? EVAL : ACCUM;
      end
      EVAL: begin
        symmetry_ok <= sym_c;
        error_ok <= err_c;
        true_delivery <= sym_c && err_c;
        st <= CHECK;
      end
      CHECK: st <= true_delivery ? SEAL : FAIL;
      SEAL: begin
        wcnt <= wcnt + 16'd1;
        if (seal_ready) begin
          seal <= seal_in;
          st <= DONE;
        end else if (wcnt == TMAX) begin
          timeout <= 1'b1;
          st <= FAIL;
        end
      end
      default: st <= IDLE;
    endcase
  end
endmodule

// File: tb/tb_iso16_delivery_controller.sv
// tb_iso16_delivery_controller: randomized loops checked every cycle against a transaction-level model
module tb_iso16_delivery_controller;
  localparam int TO = 8;
  logic clk = 0, rst = 1, start = 0, s_valid = 0, seal_ready = 0;
  logic signed [15:0] s_x = 0, s_y = 0, s_z = 0;
  logic [31:0] s_err = 0;
  logic [255:0] seal_in = 0;
  logic busy, s_ready, symmetry_ok, error_ok, true_delivery, seal_start, done, timeout;
  logic [2:0] state;
  logic signed [15:0] warp_sum_x, warp_sum_y, warp_sum_z;
  logic [31:0] error_sum;
  logic [255:0] seal;
  localparam logic [255:0] A5 = {32{8'hA5}};
  iso16_delivery_controller #(.SEAL_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_err(s_err), .state(state),
    .warp_sum_x(warp_sum_x), .warp_sum_y(warp_sum_y), .warp_sum_z(warp_sum_z), .error_sum(error_sum),
    .symmetry_ok(symmetry_ok), .error_ok(error_ok), .true_delivery(true_delivery), .seal_start(seal_start),
    .seal_ready(seal_ready), .seal_in(seal_in), .seal(seal), .done(done), .timeout(timeout)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  longint mx, my, mz, me;
  bit movf, msym, meok, mtd, mto, chk_en = 0;
  logic [255:0] mseal;
  int sx[4], sy[4], sz[4];
  longint se[4];
  typedef struct {
    logic [2:0] st;
    logic busy, srdy, sst, dn, to, sym, eok, td;
    logic [15:0] sx, sy, sz;
    logic [31:0] es;
    logic [255:0] seal;
  } exp_t;
  exp_t e;
  function automatic void chk(string n, logic [255:0] a, logic [255:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endfunction
  function automatic longint wrapped(longint v);
    return v > 32767 ? v - 65536 : v < -32768 ? v + 65536 : v;
  endfunction
  function automatic bit tol_ok(longint v);
    return (v < 0 ? -v : v) <= 0 && v != -32768;
  endfunction
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("state", 256'(state), 256'(e.st));
    chk("busy", 256'(busy), 256'(e.busy));
    chk("s_ready", 256'(s_ready), 256'(e.srdy));
    chk("seal_start", 256'(seal_start), 256'(e.sst));
    chk("done", 256'(done), 256'(e.dn));
    chk("timeout", 256'(timeout), 256'(e.to));
    chk("symmetry_ok", 256'(symmetry_ok), 256'(e.sym));
    chk("error_ok", 256'(error_ok), 256'(e.eok));
    chk("true_delivery", 256'(true_delivery), 256'(e.td));
    chk("warp_sum_x", 256'($unsigned(warp_sum_x)), 256'(e.sx));
    chk("warp_sum_y", 256'($unsigned(warp_sum_y)), 256'(e.sy));
    chk("warp_sum_z", 256'($unsigned(warp_sum_z)), 256'(e.sz));
    chk("error_sum", 256'(error_sum), 256'(e.es));
    chk("seal", seal, e.seal);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic show(input logic [2:0] s, input bit first);
    e.st = s;
    e.busy = s != 3'd0;
    e.srdy = s == 3'd2;
    e.sst = first;
    e.dn = s == 3'd6 || s == 3'd7;
    e.to = mto;
    e.sym = msym;
    e.eok = meok;
    e.td = mtd;
    e.sx = 16'(mx);
    e.sy = 16'(my);
    e.sz = 16'(mz);
    e.es = 32'(me);
    e.seal = mseal;
    chk_en = 1;
  endtask
  task automatic model_zero();
    mx = 0; my = 0; mz = 0; me = 0;
    movf = 0; msym = 0; meok = 0; mtd = 0; mto = 0; mseal = '0;
  endtask
  task automatic accept(input int i);
    mx += sx[i]; my += sy[i]; mz += sz[i];
    movf |= mx != wrapped(mx) || my != wrapped(my) || mz != wrapped(mz);
    mx = wrapped(mx); my = wrapped(my); mz = wrapped(mz);
    me += se[i];
    if (me > 64'hFFFF_FFFF) me = 64'hFFFF_FFFF;
  endtask
  task automatic noise();
    start = 1'($urandom_range(0, 1));
    seal_ready = 1'($urandom_range(0, 1));
    seal_in = rnd256();
  endtask
  task automatic set42();
    sx = '{100, 100, -100, -100};
    sy = '{100, -100, 100, -100};
    sz = '{100, -100, -100, 100};
    se = '{1, 1, 1, 1};
  endtask
  task automatic run_loop(input int dly, input int rst_at, input logic [255:0] sv);
    int i = 0;
    logic [2:0] nxt = 3'd7;
    start = 1; seal_ready = 0; show(0, 0); tick();
    noise(); show(1, 0); tick();
    model_zero();
    while (i < 4) begin
      noise();
      s_valid = ($urandom_range(0, 2) != 0) || (rst_at == i);
      if (s_valid) begin
        s_x = 16'(sx[i]); s_y = 16'(sy[i]); s_z = 16'(sz[i]); s_err = 32'(se[i]);
      end else begin
        s_x = 16'($urandom); s_y = 16'($urandom); s_z = 16'($urandom); s_err = $urandom;
      end
      if (rst_at == i) rst = 1;
      show(2, 0); tick();
      if (rst) begin
        rst = 0; s_valid = 0; start = 0; seal_ready = 0;
        model_zero(); show(0, 0);
        return;
      end
      if (s_valid) begin
        accept(i);
        i++;
      end
    end
    s_valid = 0; noise(); show(3, 0); tick();
    msym = !movf && tol_ok(mx) && tol_ok(my) && tol_ok(mz);
    meok = me <= 16;
    mtd = msym && meok;
    noise(); show(4, 0); tick();
    if (mtd) begin
      for (int w = 0; w < TO; w++) begin
        start = 1'($urandom_range(0, 1));
        seal_ready = w == dly;
        seal_in = w == dly ? sv : rnd256();
        show(5, w == 0); tick();
        if (seal_ready) begin
          mseal = sv;
          nxt = 3'd6;
          break;
        end
      end
      if (nxt == 3'd7) mto = 1;
    end
    noise(); show(nxt, 0); tick();
    start = 0; seal_ready = 0; show(0, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    model_zero();
    tick(); show(0, 0); tick();
    rst = 0; tick();
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_seal", seal, 256'(0));
    set42(); run_loop(3, -1, A5);
    chk("r42_error_sum", 256'(error_sum), 256'(4));
    chk("r42_true_delivery", 256'(true_delivery), 256'(1));
    chk("r42_seal", seal, A5);
    tick(); tick();
    set42(); sx[0] = 101; run_loop(3, -1, A5);
    chk("r43_warp_sum_x", 256'($unsigned(warp_sum_x)), 256'(1));
    chk("r43_true_delivery", 256'(true_delivery), 256'(0));
    chk("r43_seal", seal, 256'(0));
    sx = '{32767, 1, 0, 0}; sy = '{0, 0, 0, 0}; sz = '{0, 0, 0, 0}; se = '{1, 1, 1, 1};
    run_loop(3, -1, A5);
    chk("r44_warp_sum_x", 256'($unsigned(warp_sum_x)), 256'(16'h8000));
    chk("r44_symmetry_ok", 256'(symmetry_ok), 256'(0));
    set42(); run_loop(99, -1, A5);
    chk("r45_timeout", 256'(timeout), 256'(1));
    chk("r45_seal", seal, 256'(0));
    set42(); se = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF}; run_loop(3, -1, A5);
    chk("r46_error_sum", 256'(error_sum), 256'(32'hFFFF_FFFF));
    chk("r46_error_ok", 256'(error_ok), 256'(0));
    set42(); run_loop(0, -1, A5);
    chk("seal_first_cycle", seal, A5);
    set42(); run_loop(TO - 1, -1, A5);
    chk("seal_vs_expiry_seal", seal, A5);
    chk("seal_vs_expiry_timeout", 256'(timeout), 256'(0));
    set42(); run_loop(3, 2, A5);
    chk("r47_state", 256'(state), 256'(0));
    chk("r47_error_sum", 256'(error_sum), 256'(0));
    chk("r47_s_ready", 256'(s_ready), 256'(0));
    tick();
    set42(); run_loop(3, -1, A5);
    chk("r47_rerun_error_sum", 256'(error_sum), 256'(4));
    chk("r47_rerun_seal", seal, A5);
    repeat (60) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 4; j++) begin
          sx[j] = int'($signed(16'($urandom)));
          sy[j] = int'($signed(16'($urandom)));
          sz[j] = int'($signed(16'($urandom)));
          se[j] = longint'($urandom);
        end
      end else begin
        for (int j = 0; j < 3; j++) begin
          sx[j] = int'($urandom_range(0, 2000)) - 1000;
          sy[j] = int'($urandom_range(0, 2000)) - 1000;
          sz[j] = int'($urandom_range(0, 2000)) - 1000;
        end
        sx[3] = -(sx[0] + sx[1] + sx[2]);
        sy[3] = -(sy[0] + sy[1] + sy[2]);
        sz[3] = -(sz[0] + sz[1] + sz[2]);
        if ($urandom_range(0, 3) == 0) sx[3] += 1;
        for (int j = 0; j < 4; j++) se[j] = longint'($urandom_range(0, 5));
      end
      run_loop(int'($urandom_range(0, 10)), $urandom_range(0, 7) == 0 ? int'($urandom_range(0, 3)) : -1, rnd256());
      repeat ($urandom_range(0, 2)) tick();
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
